// File: rtl/input_cmd_gen_if.sv
// Button and command bundle between the I/O pads, the
// command generator and the piece-move step.
interface input_cmd_gen_if;
  logic btn_left;
  logic btn_right;
  logic btn_rotate;
  logic move_ack;
  logic left;
  logic right;
  logic rotate;
  logic overrun;

  modport master (
    output btn_left,
    output btn_right,
    output btn_rotate,
    output move_ack,
    input  left,
    input  right,
    input  rotate,
    input  overrun
  );

  modport slave (
    input  btn_left,
    input  btn_right,
    input  btn_rotate,
    input  move_ack,
    output left,
    output right,
    output rotate,
    output overrun
  );
endinterface

// File: rtl/input_cmd_gen.sv
// Button sync/debounce/edge-detect and one-deep command latch.
// AUTO_REPEAT_EN adds held-button auto-repeat for left/right.
module input_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEBOUNCE_W      = 5,
  parameter int REPEAT_DELAY    = 48,
  parameter int REPEAT_RATE     = 12,
  parameter int REPEAT_W        = 6
) (
  input logic           clka,
  input logic           restart_n,
  input_cmd_gen_if.slave io
);

  typedef enum logic {IDLE, PEND} state_e;

  localparam logic [DEBOUNCE_W-1:0] DB_LAST =
    DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  // bit 2 = left, bit 1 = right, bit 0 = rotate
  logic [2:0] raw;
  logic [2:0] s1_q, s2_q;
  logic [2:0] stable_q, stable_d;
  logic [2:0] ev_q, ev_d;
  logic [2:0][DEBOUNCE_W-1:0] cnt_q, cnt_d;

  logic [2:0] ev_all;
  logic       real_ev;
  logic [2:0] win;
  logic [2:0] cmd_q, cmd_d;
  logic       ovr_q, ovr_d;
  state_e     state_q, state_d;

  assign raw = {io.btn_left, io.btn_right, io.btn_rotate};

  function automatic logic [2:0] pick(input logic [2:0] e);
    priority case (1'b1)
      e[2]:    return 3'b100;
      e[1]:    return 3'b010;
      e[0]:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // debounce counters, stable levels and press pulses
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        cnt_d[i]    = '0;
        stable_d[i] = s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    ev_d = stable_d & ~stable_q;
  end

  // debounce state registers
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      stable_q <= '0;
      cnt_q    <= '0;
      ev_q     <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      ev_q     <= ev_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  // {left,right} direction being repeated; 0 = none
  logic [1:0]          rdir_q, rdir_d;
  logic [REPEAT_W-1:0] rcnt_q, rcnt_d;
  logic                rfirst_q, rfirst_d;
  logic                rpt_on;
  logic                rpt_hit;
  logic [2:0]          syn;
  logic [2:0]          real_win;

  // repeat timer: armed by a real press, dropped on release
  always_comb begin
    real_win = pick(ev_q);
    rpt_on   = |(rdir_q & stable_q[2:1]);
    rpt_hit  = rpt_on &&
      (rcnt_q == (rfirst_q ? REPEAT_W'(REPEAT_DELAY)
                           : REPEAT_W'(REPEAT_RATE)));
    syn      = rpt_hit ? {rdir_q, 1'b0} : 3'b000;
    rdir_d   = rdir_q;
    rcnt_d   = rcnt_q;
    rfirst_d = rfirst_q;
    if (|real_win) begin
      rdir_d   = real_win[2:1];
      rcnt_d   = REPEAT_W'(1);
      rfirst_d = 1'b1;
    end else if (!rpt_on) begin
      rdir_d   = '0;
      rcnt_d   = '0;
      rfirst_d = 1'b0;
    end else if (rpt_hit) begin
      rcnt_d   = REPEAT_W'(1);
      rfirst_d = 1'b0;
    end else begin
      rcnt_d = rcnt_q + 1'b1;
    end
  end

  // repeat timer registers
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      rdir_q   <= '0;
      rcnt_q   <= '0;
      rfirst_q <= 1'b0;
    end else begin
      rdir_q   <= rdir_d;
      rcnt_q   <= rcnt_d;
      rfirst_q <= rfirst_d;
    end
  end

  assign ev_all  = ev_q | syn;
  assign real_ev = |ev_q;
`else
  assign ev_all  = ev_q;
  assign real_ev = |ev_q;
`endif

  // command latch: next state, pending command and overrun
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    ovr_d   = 1'b0;
    win     = pick(ev_all);
    unique case (state_q)
      IDLE: begin
        if (|win) begin
          cmd_d   = win;
          state_d = PEND;
        end
      end
      PEND: begin
        if (io.move_ack) begin
          cmd_d   = win;
          state_d = (|win) ? PEND : IDLE;
        end else if (|ev_all) begin
          ovr_d = real_ev;
        end
      end
    endcase
  end

  // command latch registers
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ovr_q   <= ovr_d;
    end
  end

  assign io.left    = cmd_q[2];
  assign io.right   = cmd_q[1];
  assign io.rotate  = cmd_q[0];
  assign io.overrun = ovr_q;

endmodule

// File: tb/tb_input_cmd_gen.sv
// Randomised and directed bench for input_cmd_gen against
// a cycle-level behavioural model of the button rules.
module tb_input_cmd_gen;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RR = 3;

  logic clka      = 1'b0;
  logic restart_n = 1'b0;

  input_cmd_gen_if io();

  input_cmd_gen #(
    .DEBOUNCE_CYCLES(DB),
    .DEBOUNCE_W     (5),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .REPEAT_W       (6)
  ) dut (
    .clka     (clka),
    .restart_n(restart_n),
    .io       (io)
  );

  always #5 clka = ~clka;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: raw samples, debounced level, pending command
  logic [2:0] m_r1, m_r2, m_stab, m_pev, m_cmd;
  logic       m_ovr;
  int         m_run [3];
  logic [1:0] m_rdir;
  int         m_age;

  function automatic logic [2:0] first_of(input logic [2:0] e);
    if (e[2]) return 3'b100;
    else if (e[1]) return 3'b010;
    else if (e[0]) return 3'b001;
    else return 3'b000;
  endfunction

  task automatic m_reset();
    m_r1 = 0; m_r2 = 0; m_stab = 0; m_pev = 0;
    m_cmd = 0; m_ovr = 0; m_rdir = 0; m_age = 0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
  endtask

  task automatic m_edge(input logic [2:0] raw, input logic ack);
    logic [2:0] syn, all, w, ev, rw;
    logic       act;
    syn = 0;
    act = (m_rdir & m_stab[2:1]) != 0;
`ifdef AUTO_REPEAT_EN
    if (act && m_age >= RD && ((m_age - RD) % RR) == 0)
      syn = {m_rdir, 1'b0};
`endif
    all   = m_pev | syn;
    w     = first_of(all);
    m_ovr = 0;
    if (m_cmd == 0) begin
      if (w != 0) m_cmd = w;
    end else if (ack) begin
      m_cmd = w;
    end else if (all != 0) begin
      m_ovr = (m_pev != 0);
    end
    rw = first_of(m_pev);
    if (rw != 0) begin
      m_rdir = rw[2:1]; m_age = 1;
    end else if (!act) begin
      m_rdir = 0; m_age = 0;
    end else begin
      m_age++;
    end
    ev = 0;
    for (int i = 0; i < 3; i++) begin
      if (m_r2[i] != m_stab[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_stab[i] = m_r2[i];
          m_run[i]  = 0;
          ev[i]     = m_r2[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_pev = ev;
    m_r2  = m_r1;
    m_r1  = raw;
  endtask

  // one clock: drive at negedge, step model, compare after edge
  task automatic step(input logic [2:0] b,
                      input logic ack,
                      input logic rn);
    @(negedge clka);
    restart_n     = rn;
    io.btn_left   = b[2];
    io.btn_right  = b[1];
    io.btn_rotate = b[0];
    io.move_ack   = ack;
    @(posedge clka);
    if (!rn) m_reset();
    else m_edge(b, ack);
    #1;
    chk("left",    io.left,    m_cmd[2]);
    chk("right",   io.right,   m_cmd[1]);
    chk("rotate",  io.rotate,  m_cmd[0]);
    chk("overrun", io.overrun, m_ovr);
    chk("onehot",
        32'(io.left) + 32'(io.right) + 32'(io.rotate) <= 1, 1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(3'b000, m_cmd != 0, 1'b1);
  endtask

  logic [2:0] b;
  int         t_app [$];

  initial begin
    io.btn_left = 0; io.btn_right = 0; io.btn_rotate = 0;
    io.move_ack = 0;
    m_reset();

    // reset with left held, then release and time the latency
    for (int i = 0; i < 3; i++) step(3'b100, 1'b0, 1'b0);
    chk("rst_left", io.left, 0);
    for (int k = 1; k <= 8; k++) begin
      step(3'b100, 1'b0, 1'b1);
      if (k <= 7) chk("lat_left", io.left, k == 7);
    end
    step(3'b100, 1'b1, 1'b1);
    drain(12);

    // bouncing right never accepted
    for (int i = 0; i < 20; i++) begin
      step({1'b0, (i % 4) < 2, 1'b0}, 1'b0, 1'b1);
      chk("bounce_right", io.right, 0);
      chk("bounce_ovr", io.overrun, 0);
    end
    for (int i = 0; i < 10; i++) begin
      step(3'b000, 1'b0, 1'b1);
      chk("bounce_right", io.right, 0);
    end

    // rotate held across a long pending period, then acked
    for (int i = 0; i < 7; i++) step(3'b001, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      step(3'b001, 1'b0, 1'b1);
      chk("rot_hold", io.rotate, 1);
    end
    step(3'b001, 1'b1, 1'b1);
    chk("rot_ack", io.rotate, 0);
    for (int i = 0; i < 10; i++) begin
      step(3'b001, 1'b0, 1'b1);
      chk("rot_norpt", io.rotate, 0);
    end
    drain(10);

    // simultaneous left+rotate, then right while pending
    for (int i = 0; i < 7; i++) step(3'b101, 1'b0, 1'b1);
    chk("prio_left", io.left, 1);
    chk("prio_rot", io.rotate, 0);
    for (int k = 1; k <= 8; k++) begin
      step(3'b111, 1'b0, 1'b1);
      chk("ovr_pulse", io.overrun, k == 7);
      chk("ovr_left", io.left, 1);
    end

    // right event arrives with the ack of a pending left
    for (int i = 0; i < 10; i++) step(3'b000, 1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) step(3'b010, k == 7, 1'b1);
    chk("b2b_left", io.left, 0);
    chk("b2b_right", io.right, 1);
    drain(12);

`ifdef AUTO_REPEAT_EN
    // held left auto-repeats; ack each command as it appears
    for (int i = 0; i < 60; i++) begin
      step(i < 40 ? 3'b100 : 3'b000, m_cmd[2], 1'b1);
      if (io.left) t_app.push_back(i);
    end
    chk("rpt_count_ok", t_app.size() >= 4, 1);
    for (int i = 1; i < t_app.size(); i++)
      chk("rpt_gap", t_app[i] - t_app[i-1], i == 1 ? RD : RR);
    drain(10);
`endif

    // async reset while left is held and pending
    for (int i = 0; i < 20; i++) step(3'b100, 1'b0, 1'b1);
    #1 restart_n = 1'b0;
    #1;
    chk("arst_left", io.left, 0);
    chk("arst_right", io.right, 0);
    chk("arst_rot", io.rotate, 0);
    chk("arst_ovr", io.overrun, 0);
    m_reset();
    step(3'b100, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    drain(12);

    // random buttons, random acks, one reset mid-run
    b = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int j = 0; j < 3; j++)
        if ($urandom_range(0, 99) < 7) b[j] = ~b[j];
      step(b, $urandom_range(0, 3) == 0,
           !(i == 1500 || i == 1501));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
